// File: rtl/eth_tx_fsm.sv
// eth_tx_fsm: drains a first-word-fall-through FIFO of {eop, sop, data} words
// and transmits them as registered packets. Inserts IPG idle cycles after each
// EOP word and counts transmitted packets.
// Optional build macro ETH_TX_FRAME_CHECK_EN enables framing checks:
//   - a word without sop arriving between packets is dropped and flagged on outErr;
//   - a word with sop arriving mid-packet is flagged on outErr and still sent.
// Without the macro every popped word is sent and outErr stays 0.
module eth_tx_fsm #(
  parameter int IPG = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        inEmpty,
  input  logic [33:0] inRdData,
  output logic        outRdEn,
  output logic        outValid,
  output logic        outSop,
  output logic        outEop,
  output logic [31:0] outData,
  output logic [15:0] outPktCnt,
  output logic        outErr
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    XMIT = 2'd1,
    GAP  = 2'd2
  } state_t;

  // The gap counter counts down to zero, so it is loaded with IPG-1 on entry.
  localparam logic [3:0] GAP_LOAD = (IPG == 0) ? 4'd0 : 4'(IPG - 1);

  state_t      state_q, state_d;
  logic [3:0]  gap_q, gap_d;
  logic        valid_q, valid_d;
  logic        sop_q, sop_d;
  logic        eop_q, eop_d;
  logic        err_q, err_d;
  logic [31:0] data_q, data_d;
  logic [15:0] cnt_q, cnt_d;

  logic        pop;
  logic        xmit;
  logic        word_sop;
  logic        word_eop;
  logic [31:0] word_data;

  assign word_eop  = inRdData[33];
  assign word_sop  = inRdData[32];
  assign word_data = inRdData[31:0];

  // Pop only when the FIFO has a word and we are not pacing the inter-packet gap.
  assign pop     = !reset && !inEmpty && ((state_q == IDLE) || (state_q == XMIT));
  assign outRdEn = pop;

  // Next-state, gap counter and next registered outputs.
  always_comb begin
    state_d = state_q;
    gap_d   = gap_q;
    valid_d = 1'b0;
    sop_d   = 1'b0;
    eop_d   = 1'b0;
    err_d   = 1'b0;
    data_d  = '0;
    cnt_d   = cnt_q;
    xmit    = 1'b0;

    case (state_q)
      IDLE: begin
        if (pop) begin
`ifdef ETH_TX_FRAME_CHECK_EN
          // A stray continuation word between packets is dropped.
          if (!word_sop) begin
            err_d = 1'b1;
          end else begin
            xmit = 1'b1;
          end
`else
          xmit = 1'b1;
`endif
        end
      end
      XMIT: begin
        // An underrun simply holds XMIT with nothing transmitted.
        if (pop) begin
          xmit = 1'b1;
`ifdef ETH_TX_FRAME_CHECK_EN
          // A new sop mid-packet restarts the packet; flag the broken one.
          if (word_sop) begin
            err_d = 1'b1;
          end
`endif
        end
      end
      GAP: begin
        if (gap_q == 4'd0) begin
          state_d = IDLE;
        end else begin
          gap_d = gap_q - 4'd1;
        end
      end
      default: begin
        state_d = IDLE;
        gap_d   = 4'd0;
      end
    endcase

    if (xmit) begin
      valid_d = 1'b1;
      sop_d   = word_sop;
      eop_d   = word_eop;
      data_d  = word_data;
      if (word_eop) begin
        cnt_d = cnt_q + 16'd1;
        if (IPG == 0) begin
          state_d = IDLE;
          gap_d   = 4'd0;
        end else begin
          state_d = GAP;
          gap_d   = GAP_LOAD;
        end
      end else begin
        state_d = XMIT;
      end
    end
  end

  // State, counters and output registers; reset abandons any packet in flight.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      gap_q   <= 4'd0;
      valid_q <= 1'b0;
      sop_q   <= 1'b0;
      eop_q   <= 1'b0;
      err_q   <= 1'b0;
      data_q  <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      gap_q   <= gap_d;
      valid_q <= valid_d;
      sop_q   <= sop_d;
      eop_q   <= eop_d;
      err_q   <= err_d;
      data_q  <= data_d;
      cnt_q   <= cnt_d;
    end
  end

  assign outValid  = valid_q;
  assign outSop    = sop_q;
  assign outEop    = eop_q;
  assign outData   = data_q;
  assign outPktCnt = cnt_q;
  assign outErr    = err_q;

endmodule

// File: tb/tb_eth_tx_fsm.sv
// Bench for eth_tx_fsm: a queue-backed FWFT FIFO feeds the block; a packet-level
// model (pop allowed from a cycle number onward, packet-open flag) predicts
// every output each cycle. A second instance with IPG=0 covers back-to-back
// single-word packets.
module tb_eth_tx_fsm;

  localparam int IPG_T = 2;

  logic        clk = 1'b0;
  logic        reset;
  logic        inEmpty, inEmpty0;
  logic [33:0] inRdData, inRdData0;
  logic        outRdEn, outValid, outSop, outEop, outErr;
  logic [31:0] outData;
  logic [15:0] outPktCnt;
  logic        outRdEn0, outValid0, outSop0, outEop0, outErr0;
  logic [31:0] outData0;
  logic [15:0] outPktCnt0;

  always #5 clk = ~clk;

  eth_tx_fsm #(.IPG(IPG_T)) u_dut (
    .clk(clk), .reset(reset), .inEmpty(inEmpty), .inRdData(inRdData),
    .outRdEn(outRdEn), .outValid(outValid), .outSop(outSop), .outEop(outEop),
    .outData(outData), .outPktCnt(outPktCnt), .outErr(outErr)
  );

  eth_tx_fsm #(.IPG(0)) u_dut0 (
    .clk(clk), .reset(reset), .inEmpty(inEmpty0), .inRdData(inRdData0),
    .outRdEn(outRdEn0), .outValid(outValid0), .outSop(outSop0), .outEop(outEop0),
    .outData(outData0), .outPktCnt(outPktCnt0), .outErr(outErr0)
  );

  typedef struct {
    int          cyc;
    bit          sop;
    bit          eop;
    logic [31:0] data;
  } obs_t;

  int          errors = 0;
  int          checks = 0;
  logic [33:0] fifo[$];
  logic [33:0] fifo0[$];
  obs_t        obs[$];
  obs_t        obs0[$];
  int          err_pulses = 0;
  int          stall_pct = 0;

  // model state
  int          cyc = 0;
  int          next_allowed = 0;
  bit          in_pkt = 1'b0;
  bit          e_valid = 1'b0, e_sop = 1'b0, e_eop = 1'b0, e_err = 1'b0, e_rd;
  logic [31:0] e_data = '0;
  logic [15:0] e_cnt = '0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // per-cycle compare against the packet-level model
  initial begin
    forever begin
      @(negedge clk);
      if (reset) begin
        chk("rst_valid", 64'(outValid), 64'(0));
        chk("rst_sop", 64'(outSop), 64'(0));
        chk("rst_eop", 64'(outEop), 64'(0));
        chk("rst_data", 64'(outData), 64'(0));
        chk("rst_cnt", 64'(outPktCnt), 64'(0));
        chk("rst_err", 64'(outErr), 64'(0));
        chk("rst_rden", 64'(outRdEn), 64'(0));
        e_valid = 0; e_sop = 0; e_eop = 0; e_err = 0; e_data = '0; e_cnt = '0;
        in_pkt = 0; next_allowed = 0;
      end else begin
        chk("valid", 64'(outValid), 64'(e_valid));
        if (e_valid) begin
          chk("sop", 64'(outSop), 64'(e_sop));
          chk("eop", 64'(outEop), 64'(e_eop));
          chk("data", 64'(outData), 64'(e_data));
        end
        chk("pktcnt", 64'(outPktCnt), 64'(e_cnt));
        chk("err", 64'(outErr), 64'(e_err));
        e_rd = !inEmpty && (cyc >= next_allowed);
        chk("rden", 64'(outRdEn), 64'(e_rd));
        if (outValid) obs.push_back('{cyc, outSop, outEop, outData});
        if (outErr) err_pulses++;
        if (outValid0) obs0.push_back('{cyc, outSop0, outEop0, outData0});

        e_valid = 0; e_err = 0;
        if (e_rd) begin
`ifdef ETH_TX_FRAME_CHECK_EN
          if (!in_pkt && !inRdData[32]) begin
            e_err = 1;
          end else begin
            if (in_pkt && inRdData[32]) e_err = 1;
            e_valid = 1;
          end
`else
          e_valid = 1;
`endif
          if (e_valid) begin
            e_sop  = inRdData[32];
            e_eop  = inRdData[33];
            e_data = inRdData[31:0];
            if (inRdData[33]) begin
              e_cnt = e_cnt + 16'd1;
              next_allowed = cyc + IPG_T + 1;
              in_pkt = 0;
            end else begin
              in_pkt = 1;
            end
          end
        end
      end
      cyc++;
    end
  end

  task automatic drive();
    inEmpty   = (fifo.size() == 0) || ($urandom_range(0, 99) < stall_pct);
    inRdData  = (fifo.size() != 0) ? fifo[0] : '0;
    inEmpty0  = (fifo0.size() == 0);
    inRdData0 = (fifo0.size() != 0) ? fifo0[0] : '0;
  endtask

  task automatic step();
    bit f, f0;
    @(negedge clk);
    f  = outRdEn;
    f0 = outRdEn0;
    @(posedge clk);
    #1;
    if (f && fifo.size() != 0) void'(fifo.pop_front());
    if (f0 && fifo0.size() != 0) void'(fifo0.pop_front());
    drive();
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic drain(input int max);
    int k = 0;
    while ((fifo.size() != 0 || fifo0.size() != 0) && k < max) begin
      step();
      k++;
    end
    chk("drain_timeout", 64'(fifo.size() + fifo0.size()), 64'(0));
    run(IPG_T + 4);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    fifo.delete();
    fifo0.delete();
    drive();
    run(2);
    reset = 1'b0;
    obs.delete();
    obs0.delete();
    err_pulses = 0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int eops;
    int len;
    logic [33:0] w;

    reset = 1'b1;
    inEmpty = 1'b1; inRdData = '0; inEmpty0 = 1'b1; inRdData0 = '0;
    run(3);
    // a waiting word must not be popped while reset is held
    fifo.push_back({1'b1, 1'b1, 32'h0000_0FFF});
    drive();
    #1;
    chk("rst_hold_rden", 64'(outRdEn), 64'(0));
    chk("rst_hold_cnt", 64'(outPktCnt), 64'(0));
    fifo.delete();
    drive();
    reset = 1'b0;
    run(2);

    // four-word packet, IPG=2
    do_reset();
    fifo.push_back({1'b0, 1'b1, 32'h0000_ABCD});
    fifo.push_back({1'b0, 1'b0, 32'h0000_BEEF});
    fifo.push_back({1'b0, 1'b0, 32'h0000_1234});
    fifo.push_back({1'b1, 1'b0, 32'h0000_5678});
    drive();
    drain(50);
    chk("A_nwords", 64'(obs.size()), 64'(4));
    if (obs.size() == 4) begin
      chk("A_w0", 64'(obs[0].data), 64'(32'h0000_ABCD));
      chk("A_w0sop", 64'(obs[0].sop), 64'(1));
      chk("A_w3", 64'(obs[3].data), 64'(32'h0000_5678));
      chk("A_w3eop", 64'(obs[3].eop), 64'(1));
      chk("A_span", 64'(obs[3].cyc - obs[0].cyc), 64'(3));
    end
    chk("A_cnt", 64'(outPktCnt), 64'(1));

    // two back-to-back 3-word packets
    do_reset();
    fifo.push_back({1'b0, 1'b1, 32'h0000_00A1});
    fifo.push_back({1'b0, 1'b0, 32'h0000_00A2});
    fifo.push_back({1'b1, 1'b0, 32'h0000_00A3});
    fifo.push_back({1'b0, 1'b1, 32'h0000_00B1});
    fifo.push_back({1'b0, 1'b0, 32'h0000_00B2});
    fifo.push_back({1'b1, 1'b0, 32'h0000_00B3});
    drive();
    drain(50);
    chk("B_nwords", 64'(obs.size()), 64'(6));
    if (obs.size() == 6) begin
      chk("B_gap", 64'(obs[3].cyc - obs[2].cyc), 64'(IPG_T + 1));
      chk("B_eop", 64'(obs[2].eop), 64'(1));
      chk("B_sop", 64'(obs[3].sop), 64'(1));
      chk("B_data", 64'(obs[4].data), 64'(32'h0000_00B2));
    end
    chk("B_cnt", 64'(outPktCnt), 64'(2));

    // 3-cycle underrun after the 2nd word
    do_reset();
    fifo.push_back({1'b0, 1'b1, 32'h0000_C001});
    fifo.push_back({1'b0, 1'b0, 32'h0000_C002});
    drive();
    run(5);
    fifo.push_back({1'b0, 1'b0, 32'h0000_C003});
    fifo.push_back({1'b0, 1'b0, 32'h0000_C004});
    fifo.push_back({1'b1, 1'b0, 32'h0000_C005});
    drive();
    drain(50);
    chk("C_nwords", 64'(obs.size()), 64'(5));
    if (obs.size() == 5) begin
      chk("C_stall", 64'(obs[2].cyc - obs[1].cyc), 64'(4));
      chk("C_w2", 64'(obs[2].data), 64'(32'h0000_C003));
      chk("C_w4", 64'(obs[4].data), 64'(32'h0000_C005));
      chk("C_w4eop", 64'(obs[4].eop), 64'(1));
    end
    chk("C_cnt", 64'(outPktCnt), 64'(1));

    // stray non-sop word while idle, then a good packet
    do_reset();
    fifo.push_back({1'b0, 1'b0, 32'h0000_DEAD});
    fifo.push_back({1'b0, 1'b1, 32'h0000_0011});
    fifo.push_back({1'b1, 1'b0, 32'h0000_0022});
    drive();
    drain(50);
`ifdef ETH_TX_FRAME_CHECK_EN
    chk("D_nwords", 64'(obs.size()), 64'(2));
    chk("D_errs", 64'(err_pulses), 64'(1));
    if (obs.size() == 2) chk("D_first", 64'(obs[0].data), 64'(32'h0000_0011));
`else
    chk("D_nwords", 64'(obs.size()), 64'(3));
    chk("D_errs", 64'(err_pulses), 64'(0));
    if (obs.size() == 3) chk("D_first", 64'(obs[0].data), 64'(32'h0000_DEAD));
`endif
    chk("D_cnt", 64'(outPktCnt), 64'(1));

    // reset after the 2nd word of a 5-word packet
    do_reset();
    for (int i = 0; i < 5; i++)
      fifo.push_back({(i == 4) ? 1'b1 : 1'b0, (i == 0) ? 1'b1 : 1'b0, 32'hE000_0000 + 32'(i)});
    drive();
    run(2);
    reset = 1'b1;
    #1;
    chk("E_async_valid", 64'(outValid), 64'(0));
    chk("E_async_data", 64'(outData), 64'(0));
    chk("E_async_sop", 64'(outSop), 64'(0));
    chk("E_async_rden", 64'(outRdEn), 64'(0));
    run(2);
    fifo.delete();
    drive();
    reset = 1'b0;
    run(5);
    eops = 0;
    foreach (obs[i]) if (obs[i].eop) eops++;
    chk("E_noeop", 64'(eops), 64'(0));
    chk("E_nwords", 64'(obs.size()), 64'(1));
    chk("E_cnt", 64'(outPktCnt), 64'(0));

    // randomized packets with random FIFO stalls
    do_reset();
    stall_pct = 25;
    for (int p = 0; p < 40; p++) begin
      len = $urandom_range(1, 6);
      for (int i = 0; i < len; i++) begin
        w = {(i == len - 1) ? 1'b1 : 1'b0, (i == 0) ? 1'b1 : 1'b0, 32'($urandom)};
        if (i == 0 && $urandom_range(0, 7) == 0) w[32] = 1'b0;
        fifo.push_back(w);
      end
      drive();
      run($urandom_range(0, 4));
    end
    drain(3000);
    stall_pct = 0;

    // IPG=0 instance: three single-word packets back to back
    do_reset();
    fifo0.push_back({1'b1, 1'b1, 32'h0000_0001});
    fifo0.push_back({1'b1, 1'b1, 32'h0000_0002});
    fifo0.push_back({1'b1, 1'b1, 32'h0000_0003});
    drive();
    drain(50);
    chk("Z_nwords", 64'(obs0.size()), 64'(3));
    if (obs0.size() == 3) begin
      for (int i = 0; i < 3; i++) begin
        chk("Z_data", 64'(obs0[i].data), 64'(i + 1));
        chk("Z_sopeop", 64'({obs0[i].sop, obs0[i].eop}), 64'(3));
      end
      chk("Z_span", 64'(obs0[2].cyc - obs0[0].cyc), 64'(2));
    end
    chk("Z_cnt", 64'(outPktCnt0), 64'(3));
    chk("Z_err", 64'(outErr0), 64'(0));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/eth_tx_fsm.md
ETH_TX_FSM -- requirements
Module: eth_tx_fsm

Interface
REQ-001: The block SHALL have parameter IPG, default 2 (range 0..15): idle cycles inserted after every EOP word.
REQ-002: The block SHALL have port clk, input, 1: the single clock; all state changes on its rising edge.
REQ-003: The block SHALL have port reset, input, 1: asynchronous, active-high reset.
REQ-004: The block SHALL have port inEmpty, input, 1: the first-word-fall-through FIFO is empty.
REQ-005: The block SHALL have port inRdData, input, 34: FIFO head word {eop, sop, data[31:0]}, valid whenever inEmpty=0.
REQ-006: The block SHALL have port outRdEn, output, 1: pops the FIFO head word this cycle.
REQ-007: The block SHALL have port outValid, output, 1: outData/outSop/outEop carry a word this cycle.
REQ-008: The block SHALL have port outSop, output, 1: the current word is the first of its packet.
REQ-009: The block SHALL have port outEop, output, 1: the current word is the last of its packet.
REQ-010: The block SHALL have port outData, output, 32: transmitted word.
REQ-011: The block SHALL have port outPktCnt, output, 16: count of EOP words transmitted; wraps 0xFFFF->0.
REQ-012: The block SHALL have port outErr, output, 1: one-cycle framing-error pulse.

Function
REQ-013: The block SHALL implement states IDLE, XMIT and GAP.
REQ-014: outRdEn SHALL be combinational: outRdEn = !inEmpty && (state==IDLE || state==XMIT); no pops in GAP.
REQ-015: outValid, outSop, outEop and outData SHALL be registered; a transmitted word popped in cycle N appears in cycle N+1 with outValid=1, and outValid SHALL be 0 in every cycle with no transmitted word.
REQ-016: IDLE with a popped word where sop=1: transmit it; go to GAP if eop=1 (or to IDLE if IPG=0), else go to XMIT.
REQ-017: XMIT with a popped word: transmit it; on eop=1 go to GAP (IDLE if IPG=0); a FIFO underrun (inEmpty=1) SHALL hold XMIT with outValid=0.
REQ-018: The GAP counter SHALL load IPG-1 on entry, decrement each cycle and return to IDLE after IPG cycles, so the earliest next pop after an EOP pop in cycle N is cycle N+IPG+1.
REQ-019: outPktCnt SHALL increment in the same cycle outValid&&outEop is driven.
REQ-020: A word with sop=1 and eop=1 SHALL be a legal one-word packet.
REQ-021: data[31:0] SHALL pass through bit-exact; no reordering or modification.

Reset
REQ-022: While reset=1, the block SHALL force state=IDLE, GAP counter=0, outValid/outSop/outEop/outErr=0, outData=0, outPktCnt=0 and outRdEn=0.
REQ-023: Reset mid-packet SHALL abandon the packet without emitting an EOP and without incrementing outPktCnt.
REQ-024: After reset deasserts, the first pop SHALL occur no earlier than the first clock edge with reset=0.

Configuration
REQ-025: With macro ETH_TX_FRAME_CHECK_EN defined, a word popped in IDLE with sop=0 SHALL be discarded, not transmitted, with outErr=1 for one cycle (cycle N+1).
REQ-026: With ETH_TX_FRAME_CHECK_EN defined, a word popped in XMIT with sop=1 SHALL raise outErr for one cycle and be transmitted as the start of a new packet, leaving the state in XMIT.
REQ-027: With ETH_TX_FRAME_CHECK_EN undefined, every popped word SHALL be transmitted unchanged, state transitions SHALL follow REQ-016/017 treating any IDLE word as a start, and outErr SHALL be tied 0.

Verification
REQ-028: IPG=2, FIFO preloaded with {0,1,ABCD}, {0,0,BEEF}, {0,0,1234}, {1,0,5678} -> four consecutive outValid cycles with outSop on ABCD and outEop on 5678; outPktCnt=1.
REQ-029: Two back-to-back 3-word packets, IPG=2 -> exactly 2 outValid=0 cycles between EOP and next SOP; outRdEn low in those cycles; outPktCnt=2.
REQ-030: IPG=0, three single-word packets {1,1,0001..0003} -> three consecutive outValid cycles, each with outSop=outEop=1; outPktCnt=3.
REQ-031: inEmpty=1 for 3 cycles after the 2nd word of a packet -> outValid=0 for 3 cycles, then the packet resumes intact.
REQ-032: ETH_TX_FRAME_CHECK_EN defined, IDLE head {0,0,DEAD} then a valid packet -> DEAD never on outData, one outErr pulse, valid packet transmitted; macro undefined -> DEAD transmitted, outErr=0.
REQ-033: reset pulsed after the 2nd word of a 5-word packet -> all outputs 0 asynchronously, outPktCnt=0, no outEop emitted.
